// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if: key level in, gesture event pulses out
interface key_event_decoder_if;
  logic key_filter;
  logic click_pulse;
  logic dclick_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;
  modport master (
    output key_filter,
    input  click_pulse, dclick_pulse, long_pulse, repeat_pulse, key_held
  );
  modport slave (
    input  key_filter,
    output click_pulse, dclick_pulse, long_pulse, repeat_pulse, key_held
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key gestures into click/double/long/repeat pulses
module key_event_decoder #(
  parameter int               CNT_W      = 26,
  parameter logic [CNT_W-1:0] LONG_CNT   = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0] REPEAT_CNT = CNT_W'(5_000_000),
  parameter logic [CNT_W-1:0] DCLICK_CNT = CNT_W'(15_000_000),
  parameter bit               DCLICK_EN  = 1'b1
) (
  input logic               sys_clk,
  input logic               sys_rst,
  key_event_decoder_if.slave kif
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_M1   = LONG_CNT - 1'b1;
  localparam logic [CNT_W-1:0] REPEAT_M1 = REPEAT_CNT - 1'b1;
  localparam logic [CNT_W-1:0] DCLICK_M1 = DCLICK_CNT - 1'b1;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_q;
  logic             click_q, dclick_q, long_q, repeat_q, held_q;
  logic             press_e, rel_e;
  assign press_e = key_q & ~kif.key_filter;
  assign rel_e   = ~key_q & kif.key_filter;
  assign kif.click_pulse  = click_q;
  assign kif.dclick_pulse = dclick_q;
  assign kif.long_pulse   = long_q;
  assign kif.repeat_pulse = repeat_q;
  assign kif.key_held     = held_q;
  // Gesture FSM; the shared counter clears on every state change and pulses last one cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_q    <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      key_q    <= kif.key_filter;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      cnt_q    <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (press_e) begin
            state_q <= PRESS1;
            held_q  <= 1'b1;
          end
        end
        PRESS1: begin
          if (rel_e) begin
            cnt_q   <= '0;
            held_q  <= 1'b0;
            state_q <= DCLICK_EN ? WAIT2 : IDLE;
            click_q <= !DCLICK_EN;
          end else if (cnt_q == LONG_M1) begin
            cnt_q   <= '0;
            long_q  <= 1'b1;
            state_q <= LONG;
          end
        end
        LONG: begin
          if (rel_e) begin
            cnt_q   <= '0;
            held_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == REPEAT_M1) begin
            cnt_q    <= '0;
            repeat_q <= 1'b1;
          end
        end
        WAIT2: begin
          if (press_e) begin
            cnt_q   <= '0;
            held_q  <= 1'b1;
            state_q <= PRESS2;
          end else if (cnt_q == DCLICK_M1) begin
            cnt_q   <= '0;
            click_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        PRESS2: begin
          cnt_q <= '0;
          if (rel_e) begin
            held_q   <= 1'b0;
            dclick_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          held_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: scoreboard bench for click, double click, long press and repeat events
module tb_key_event_decoder;
  typedef struct {int d; int k; int c;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  q[$];
  key_event_decoder_if ki0 ();
  key_event_decoder_if ki1 ();
  key_event_decoder #(.CNT_W(26), .LONG_CNT(26'd20), .REPEAT_CNT(26'd5), .DCLICK_CNT(26'd10), .DCLICK_EN(1'b1))
    dut0 (.sys_clk(clk), .sys_rst(rst), .kif(ki0));
  key_event_decoder #(.CNT_W(26), .LONG_CNT(26'd20), .REPEAT_CNT(26'd5), .DCLICK_CNT(26'd10), .DCLICK_EN(1'b0))
    dut1 (.sys_clk(clk), .sys_rst(rst), .kif(ki1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: every pulse seen must match the oldest expected event (dut, kind 0=click 1=dclick 2=long 3=repeat, edge)
  always @(negedge clk) begin
    logic [3:0] p;
    ev_t e;
    for (int d = 0; d < 2; d++) begin
      p = (d == 0) ? {ki0.repeat_pulse, ki0.long_pulse, ki0.dclick_pulse, ki0.click_pulse}
                   : {ki1.repeat_pulse, ki1.long_pulse, ki1.dclick_pulse, ki1.click_pulse};
      if (p != 4'b0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse dut=%0d pulses=%b edge=%0d required=no pulse", d, p, cyc);
        end else begin
          e = q.pop_front();
          if (e.d != d || p != 4'(1 << e.k) || e.c != cyc) begin
            errors++;
            $display("FAIL event dut=%0d pulses=%b edge=%0d required dut=%0d pulses=%b edge=%0d",
                     d, p, cyc, e.d, 4'(1 << e.k), e.c);
          end
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", n, a, x);
    end
  endtask
  task automatic expect_ev(input int d, input int k, input int c);
    q.push_back('{d, k, c});
  endtask
  // Drive a key level at a negedge; e is the edge that first samples it
  task automatic drive(input int d, input logic v, output int e);
    @(negedge clk);
    if (d == 0) ki0.key_filter = v;
    else ki1.key_filter = v;
    e = cyc + 1;
  endtask
  task automatic idle(input int n);
    repeat (n - 1) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d required=finish", cyc);
    $fatal(1);
  end
  initial begin
    int p, r, p2, r2;
    bit ok;
    ki0.key_filter = 1'b1;
    ki1.key_filter = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs_dut0", {27'b0, ki0.click_pulse, ki0.dclick_pulse, ki0.long_pulse, ki0.repeat_pulse, ki0.key_held}, 0);
    chk("reset_outs_dut1", {27'b0, ki1.click_pulse, ki1.dclick_pulse, ki1.long_pulse, ki1.repeat_pulse, ki1.key_held}, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_held", {31'b0, ki0.key_held}, 0);
    // single click
    drive(0, 1'b0, p);
    idle(5);
    chk("click_held", {31'b0, ki0.key_held}, 1);
    drive(0, 1'b1, r);
    expect_ev(0, 0, r + 10);
    idle(21);
    // double click
    drive(0, 1'b0, p);
    idle(5);
    drive(0, 1'b1, r);
    idle(4);
    drive(0, 1'b0, p2);
    idle(3);
    drive(0, 1'b1, r2);
    expect_ev(0, 1, r2);
    idle(20);
    // long press with four repeats, held across 42 edges
    drive(0, 1'b0, p);
    expect_ev(0, 2, p + 20);
    for (int k = 1; k <= 4; k++) expect_ev(0, 3, p + 20 + 5 * k);
    ok = 1'b1;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (ki0.key_held !== 1'b1) ok = 1'b0;
    end
    chk("long_held_throughout", {31'b0, ok}, 1);
    drive(0, 1'b1, r);
    idle(20);
    chk("long_released_held", {31'b0, ki0.key_held}, 0);
    // second press lands exactly on the double-click timeout edge
    drive(0, 1'b0, p);
    idle(5);
    drive(0, 1'b1, r);
    idle(10);
    drive(0, 1'b0, p2);
    idle(3);
    drive(0, 1'b1, r2);
    expect_ev(0, 1, r2);
    idle(20);
    // release one edge before the long threshold takes the click path
    drive(0, 1'b0, p);
    idle(19);
    drive(0, 1'b1, r);
    expect_ev(0, 0, r + 10);
    idle(21);
    // reset in the middle of a long press, key kept low through reset
    drive(0, 1'b0, p);
    expect_ev(0, 2, p + 20);
    idle(23);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_long_held", {31'b0, ki0.key_held}, 0);
    @(negedge clk) rst = 1'b0;
    p2 = cyc + 1;
    expect_ev(0, 2, p2 + 20);
    @(negedge clk);
    chk("repress_after_reset_held", {31'b0, ki0.key_held}, 1);
    idle(21);
    drive(0, 1'b1, r);
    idle(20);
    // reset while waiting for a second press
    drive(0, 1'b0, p);
    idle(5);
    drive(0, 1'b1, r);
    idle(5);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_wait2_held", {31'b0, ki0.key_held}, 0);
    idle(20);
    // double-click detection disabled: each release is a click
    drive(1, 1'b0, p);
    idle(5);
    drive(1, 1'b1, r);
    expect_ev(1, 0, r);
    idle(2);
    drive(1, 1'b0, p2);
    idle(3);
    drive(1, 1'b1, r2);
    expect_ev(1, 0, r2);
    idle(20);
    chk("events_outstanding", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the debounced, active-low key level from the key debounce stage.
- Classifies each key gesture as a single click, double click, long press or auto-repeat while held.
- Emits one-cycle event pulses to the DAC control logic, e.g. channel select or code step up/down.
- Sits directly downstream of the debouncer, in the same sys_clk domain. No synchronisation is needed.

Parameters:
- LONG_CNT, 26'd50_000_000, press duration in cycles before a long press (1 s at 50 MHz).
- REPEAT_CNT, 26'd5_000_000, auto-repeat period in cycles while in long press (100 ms).
- DCLICK_CNT, 26'd15_000_000, maximum released gap in cycles before a second press counts as a double click (300 ms).
- DCLICK_EN, 1'b1, 1 = double-click detection enabled; 0 = release reports a click immediately.
- CNT_W, 26, width of the shared duration counter. Must hold max(LONG_CNT, REPEAT_CNT, DCLICK_CNT).

Ports:
- sys_clk  input  1  system clock, 50 MHz
- sys_rst  input  1  synchronous reset, active-high
- key_filter  input  1  debounced key level; 0 = pressed, 1 = released
- click_pulse  output  1  single-click event, one cycle
- dclick_pulse  output  1  double-click event, one cycle
- long_pulse  output  1  long-press start event, one cycle
- repeat_pulse  output  1  auto-repeat tick during long press, one cycle
- key_held  output  1  high while the FSM considers the key pressed

Behaviour:
- Reset is synchronous, sampled on the sys_clk rising edge. The reset state is:
  - key_r = 1, state = IDLE, cnt = 0;
  - all pulse outputs = 0, key_held = 0.
  - Reset mid-gesture aborts it silently; no pulse is emitted.
- Edge detection:
  - key_r registers key_filter.
  - press_e = key_r & ~key_filter; rel_e = ~key_r & key_filter.
  - A key already low when reset deasserts produces press_e in the first cycle.
- All outputs are registered. A pulse is high for exactly one cycle, the cycle after the qualifying condition is sampled.
- key_held = 1 in PRESS1, PRESS2 and LONG.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG. cnt clears on every state change.
- IDLE: press_e -> PRESS1.
- PRESS1: cnt increments each cycle.
  - rel_e with DCLICK_EN=1 -> WAIT2.
  - rel_e with DCLICK_EN=0 -> click_pulse, then IDLE.
  - Key still low with cnt == LONG_CNT-1 -> long_pulse, then LONG.
- LONG: cnt increments.
  - cnt == REPEAT_CNT-1 -> repeat_pulse and cnt wraps to 0.
  - rel_e -> IDLE, with no click and no repeat emitted on that cycle.
- WAIT2: cnt increments.
  - press_e -> PRESS2.
  - cnt == DCLICK_CNT-1 with no press -> click_pulse, then IDLE.
  - press_e in the same cycle as the timeout: the press wins -> PRESS2, no click.
- PRESS2: cnt does not trigger anything. Duration is ignored, with no long press from the second press.
  - rel_e -> dclick_pulse, then IDLE.
- At most one output pulse is asserted per cycle.
- cnt never exceeds the active threshold and never wraps uncontrolled.
- A press shorter than one cycle cannot occur, because the input is debounced.
- Timing: if press_e is sampled at edge T, long_pulse is high in cycle T+1+LONG_CNT. The k-th repeat_pulse follows at long_pulse + k*REPEAT_CNT.

Test Plan (bench uses LONG_CNT=20, REPEAT_CNT=5, DCLICK_CNT=10, DCLICK_EN=1):
- Reset with key_filter=1: all outputs 0. Hold key_filter=1 for 100 cycles -> no pulses, key_held=0.
- Single click: press 5 cycles, release, idle 20 cycles -> exactly one click_pulse, 10 cycles after release is sampled. No other pulse.
- Double click: press 5, release 4, press 3, release -> one dclick_pulse, one cycle after the second release. No click_pulse.
- Long press: press held 42 cycles, then release.
  - long_pulse at T+21.
  - repeat_pulse at T+26, T+31, T+36, T+41.
  - Nothing after release. key_held high throughout the hold.
- Boundaries:
  - Second press arriving exactly on the WAIT2 timeout cycle -> dclick, no click.
  - Release on cnt=LONG_CNT-2 in PRESS1 -> click path, no long_pulse.
- Reset asserted mid-LONG and mid-WAIT2 -> no pulse emitted. FSM is in IDLE one cycle after reset deasserts. Key held low through reset -> long press restarts from press_e.
- DCLICK_EN=0 variant: press 5, release -> click_pulse one cycle after release. A rapid second press yields a second click, never a dclick.
